vga_sync_generator: RTL
=======================

# vga_sync_generator

- Raster timing stage: consumes the one-cycle pixel-tick pulse from the upstream clock-divider counter (its terminal-count output).
- Produces horizontal/vertical pixel coordinates, active-low sync pulses, a visible-area flag, and line/frame pulses.
- Downstream consumers are the sprite, pipe and score renderers plus the game-logic frame update.
- Default timing is 640x480 @ 60 Hz (800x525 total).

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HW, 10, pixel_x width; must hold H_TOTAL-1
- VW, 10, pixel_y width; must hold V_TOTAL-1

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- pix_tick  input  1  one-clk advance pulse from the upstream divider; may also be held high
- pixel_x  output  HW  current column, 0..H_TOTAL-1
- pixel_y  output  VW  current line, 0..V_TOTAL-1
- hsync  output  1  active-low horizontal sync
- vsync  output  1  active-low vertical sync
- video_on  output  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
- line_tick  output  1  pix_tick AND (pixel_x == H_TOTAL-1)
- frame_tick  output  1  line_tick AND (pixel_y == V_TOTAL-1)

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
- Horizontal counter:
  - Advances only on a clk edge with pix_tick=1.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Advances only on the same edge the horizontal counter wraps.
  - At V_TOTAL-1 it wraps to 0.
- hsync is low when pixel_x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; high otherwise.
- vsync is low when pixel_y is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]; high otherwise.
- hsync, vsync and video_on are registered:
  - Each is computed from the next-state counter values.
  - All three therefore describe exactly the pixel_x/pixel_y present on the same cycle. No skew between coordinates and sync.
- line_tick and frame_tick are combinational, one clk wide.
  - They assert on the cycle before the wrap takes effect, so downstream logic can register on the same edge.
- pix_tick=0: all registers hold; line_tick and frame_tick are 0.
- Arithmetic:
  - Counters are unsigned and compared with >=/== against parameter-derived constants.
  - No overflow is possible, given the HW/VW constraint.

## Timing
- Reset state (asynchronous on rst falling; released synchronously by design usage):
  - pixel_x=0, pixel_y=0
  - hsync=1, vsync=1, video_on=1 (consistent with pixel (0,0))
  - line_tick=0, frame_tick=0
- Latency: one clk from a pix_tick edge to updated coordinates/syncs.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for clk.
- After reset release, the first pix_tick moves to (1,0).
- Continuous pix_tick=1: one pixel per clk; a frame is exactly H_TOTAL*V_TOTAL clks.
- Simultaneous horizontal and vertical wrap at (H_TOTAL-1, V_TOTAL-1): the next state is (0,0) in a single step.

## Structure
- Shared package vga_timing_pkg:
  - Default porch/sync constants
  - Derived H_TOTAL/V_TOTAL
  - Sync start/end constants
- Sub-module sync_axis_counter, instantiated twice (horizontal, vertical):
  - Inputs: advance enable and wrap limit.
  - Outputs: count, next count, at_max flag.
  - The top level adds sync/video decode and the output registers.

## Test plan
- Reset: hold rst=0 with pix_tick toggling -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, line_tick=0.
- Line wrap: pix_tick=1, run to pixel_x=799, pixel_y=0 -> line_tick=1 that cycle; next clk (0,1), line_tick=0.
- hsync window: scan line 0 -> hsync=0 for exactly pixel_x 656..751 (96 clks); video_on=0 from pixel_x 640 onward.
- Frame wrap: run to (799,524) -> frame_tick=1 for one clk, then (0,0). vsync=0 only on lines 490-491. Frame length is 420000 clks.
- Stall: pix_tick pulsed once every 4 clks -> coordinates advance once per pulse and hold otherwise; line_tick width is 1 clk.
- Async reset mid-frame: at (300,200) drop rst between clk edges -> outputs return to reset values before the next edge; after release, counting resumes from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default VGA raster timing for 640x480 @ 60 Hz, plus a small window-decode helper.
// Per-instance totals are re-derived in the top level from its own parameters.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;

    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // Inclusive range test used for both sync windows.
    function automatic logic in_window(input int unsigned value,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: a wrapping counter that exposes its current and next value.
// The next value lets the parent register decode results aligned with the count.
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_advance,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next,
    output logic         o_at_max
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         w_at_max;

    assign w_at_max = (r_count == i_limit);

    always_comb begin
        w_count_next = r_count;
        if (i_advance) begin
            w_count_next = w_at_max ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_at_max     = w_at_max;

endmodule

// File: rtl/vga_sync_generator.sv
// Raster timing generator: pixel coordinates, active-low syncs, visible flag and
// line/frame pulses, advanced by an upstream pixel-tick pulse.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned HW        = 10,
    parameter int unsigned VW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_tick,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_tick,
    output logic          frame_tick
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

    logic [HW-1:0] w_h_count;
    logic [HW-1:0] w_h_next;
    logic          w_h_at_max;
    logic [VW-1:0] w_v_count;
    logic [VW-1:0] w_v_next;
    logic          w_v_at_max;
    logic          w_v_advance;
    logic          w_line_tick;
    logic          w_frame_tick;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;

    assign w_v_advance = pix_tick & w_h_at_max;

    sync_axis_counter #(
        .W (HW)
    ) u_h_counter (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (pix_tick),
        .i_limit      (H_MAX),
        .o_count      (w_h_count),
        .o_count_next (w_h_next),
        .o_at_max     (w_h_at_max)
    );

    sync_axis_counter #(
        .W (VW)
    ) u_v_counter (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_v_advance),
        .i_limit      (V_MAX),
        .o_count      (w_v_count),
        .o_count_next (w_v_next),
        .o_at_max     (w_v_at_max)
    );

    assign w_line_tick  = w_v_advance;
    assign w_frame_tick = w_line_tick & w_v_at_max;

    // Decode from the next-state counts so the registered flags line up with the
    // coordinates that appear on the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b1;
        end else begin
            r_hsync    <= ~in_window(32'(w_h_next), HS_START, HS_END);
            r_vsync    <= ~in_window(32'(w_v_next), VS_START, VS_END);
            r_video_on <= (32'(w_h_next) < H_VISIBLE) && (32'(w_v_next) < V_VISIBLE);
        end
    end

    assign pixel_x    = w_h_count;
    assign pixel_y    = w_v_count;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign line_tick  = w_line_tick;
    assign frame_tick = w_frame_tick;

endmodule
